spi_pixel_rx: RTL and testbench

//  SPI slave front end that takes frames from the Pi and deserialises them into

---
 rtl/spi_pixel_rx.sv | 180 ++++++++++++++++++
 tb/tb_spi_pixel_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pixel_rx.sv
// spi_pixel_rx
//   SPI slave front end. Deserialises LSB-first pixel words shifted in on sck
//   while cs_n is low and presents them as addressed frame-buffer writes. Once a
//   full frame of 2**FRAME_ORDER pixels has been emitted the block holds off any
//   further data until the downstream double-buffer controller acknowledges it.
//
// Ports
//   clk        system clock; every register lives in this domain
//   reset      synchronous, active-high
//   sck        raw SPI clock (asynchronous)
//   sdi        raw SPI data (asynchronous)
//   cs_n       raw SPI chip select, active low (asynchronous)
//   frame_ack  downstream has consumed the held frame
//   pix_valid  one-cycle strobe qualifying pix_data / pix_addr
//   pix_data   received pixel, first bit received in bit 0
//   pix_addr   pixel index within the frame
//   frame_done one-cycle pulse alongside the last pixel of a frame
//   frame_err  one-cycle pulse when cs_n rises before the frame is full
//   overrun    sticky, set by an sck rise while a frame is held
//   busy       high while receiving or holding a frame
module spi_pixel_rx #(
    parameter int CDEPTH      = 4,
    parameter int FRAME_ORDER = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   sdi,
    input  logic                   cs_n,
    input  logic                   frame_ack,
    output logic                   pix_valid,
    output logic [3*CDEPTH-1:0]    pix_data,
    output logic [FRAME_ORDER-1:0] pix_addr,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic                   overrun,
    output logic                   busy
);

    localparam int PW = 3 * CDEPTH;
    localparam int BW = $clog2(PW);
    localparam logic [BW-1:0]          LAST_BIT = BW'(PW - 1);
    localparam logic [FRAME_ORDER-1:0] LAST_PIX = '1;

    // Synchroniser lanes: 0 = sck, 1 = sdi, 2 = cs_n. cs_n resets to the
    // deselected level so a reset never looks like the start of a frame.
    localparam logic [2:0] SYNC_INIT = 3'b100;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RECV       = 2'd1,
        HOLD       = 2'd2,
        WAIT_CS_HI = 2'd3
    } state_t;

    logic [2:0] raw_in;
    logic [2:0] sync_s;

    assign raw_in = {cs_n, sdi, sck};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= SYNC_INIT[gi];
                    sync_reg <= SYNC_INIT[gi];
                end else begin
                    meta_reg <= raw_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sync_s[gi] = sync_reg;
        end
    endgenerate

    logic sck_s;
    logic sdi_s;
    logic cs_s;
    logic sck_s_d_reg;
    logic rise;

    assign sck_s = sync_s[0];
    assign sdi_s = sync_s[1];
    assign cs_s  = sync_s[2];
    assign rise  = sck_s & ~sck_s_d_reg;

    state_t                 state_reg;
    logic [BW-1:0]          bcount_reg;
    logic [FRAME_ORDER-1:0] pcount_reg;
    logic [PW-1:0]          sh_reg;
    logic [PW-1:0]          sh_next;

    assign sh_next = {sdi_s, sh_reg[PW-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bcount_reg  <= '0;
            pcount_reg  <= '0;
            sh_reg      <= '0;
            sck_s_d_reg <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_addr    <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sck_s_d_reg <= sck_s;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (!cs_s) begin
                        state_reg  <= RECV;
                        busy       <= 1'b1;
                        bcount_reg <= '0;
                        pcount_reg <= '0;
                        sh_reg     <= '0;
                    end
                end

                RECV: begin
                    // A pixel-completing rise outranks a simultaneous cs_n
                    // rise, so the last pixel of a frame is never lost.
                    if (rise && bcount_reg == LAST_BIT) begin
                        sh_reg     <= sh_next;
                        pix_valid  <= 1'b1;
                        pix_data   <= sh_next;
                        pix_addr   <= pcount_reg;
                        bcount_reg <= '0;
                        pcount_reg <= pcount_reg + 1'b1;
                        if (pcount_reg == LAST_PIX) begin
                            frame_done <= 1'b1;
                            state_reg  <= HOLD;
                        end
                    end else if (cs_s) begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end else if (rise) begin
                        sh_reg     <= sh_next;
                        bcount_reg <= bcount_reg + 1'b1;
                    end
                end

                HOLD: begin
                    // Ack beats a coincident rise so overrun ends cleared.
                    if (frame_ack) begin
                        overrun   <= 1'b0;
                        busy      <= 1'b0;
                        state_reg <= cs_s ? IDLE : WAIT_CS_HI;
                    end else if (rise && !cs_s) begin
                        overrun <= 1'b1;
                    end
                end

                WAIT_CS_HI: begin
                    // Each new frame must begin on a fresh cs_n falling edge.
                    if (cs_s) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pixel_rx.sv
`timescale 1ns/1ps
module tb_spi_pixel_rx;

    localparam int CDEPTH = 4;
    localparam int FO     = 5;
    localparam int PW     = 3 * CDEPTH;
    localparam int NPIX   = 1 << FO;

    logic          clk = 1'b0;
    logic          reset;
    logic          sck;
    logic          sdi;
    logic          cs_n;
    logic          frame_ack;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic [FO-1:0] pix_addr;
    logic          frame_done;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    spi_pixel_rx #(.CDEPTH(CDEPTH), .FRAME_ORDER(FO)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .sdi        (sdi),
        .cs_n       (cs_n),
        .frame_ack  (frame_ack),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_addr   (pix_addr),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model of the link at frame/pixel level.
    bit m_accept = 0;      // a frame is being collected
    bit m_held   = 0;      // a full frame awaits acknowledge
    int m_pcount = 0;
    int exp_err  = 0;
    bit exp_ovr  = 0;
    int err_seen = 0;
    logic [PW+FO:0] exp_q[$];   // {last, addr, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input bit with_cs);
        sdi = b;
        tick($urandom_range(2, 3));
        sck = 1'b1;
        if (with_cs) cs_n = 1'b1;
        if (m_held && !cs_n) exp_ovr = 1'b1;
        tick($urandom_range(2, 3));
        sck = 1'b0;
    endtask

    // Sends one full pixel; the last bit optionally coincides with cs_n rising.
    task automatic send_pixel(input logic [PW-1:0] d, input bit cs_on_last);
        if (m_accept) begin
            exp_q.push_back({(m_pcount == NPIX - 1), FO'(m_pcount), d});
            m_pcount++;
            if (m_pcount == NPIX) begin
                m_accept = 0;
                m_held   = 1;
            end
        end
        for (int i = 0; i < PW; i++) send_bit(d[i], cs_on_last && (i == PW - 1));
    endtask

    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic frame_start;
        cs_n = 1'b0;
        if (!m_held) begin
            m_accept = 1;
            m_pcount = 0;
        end
        tick(4);
    endtask

    task automatic frame_end;
        cs_n = 1'b1;
        if (m_accept) begin
            exp_err++;
            m_accept = 0;
        end
        tick(4);
    endtask

    task automatic ack;
        frame_ack = 1'b1;
        tick(1);
        frame_ack = 1'b0;
        if (m_held) begin
            m_held  = 0;
            exp_ovr = 0;
        end
        tick(2);
    endtask

    task automatic send_frame_pixels(input int n);
        for (int i = 0; i < n; i++) send_pixel(PW'($urandom), 1'b0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Monitor: pops an expectation for every strobe the DUT presents.
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_valid) begin
                logic [PW+FO:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pix actual addr=%0d data=%0h required none", pix_addr, pix_data);
                end else begin
                    e = exp_q.pop_front();
                    if (pix_addr !== e[PW+FO-1:PW] || pix_data !== e[PW-1:0] || frame_done !== e[PW+FO]) begin
                        errors++;
                        $display("FAIL pix actual addr=%0d data=%0h done=%0b required addr=%0d data=%0h done=%0b",
                                 pix_addr, pix_data, frame_done, e[PW+FO-1:PW], e[PW-1:0], e[PW+FO]);
                    end else begin
                        $display("pix addr=%0d data=%03h done=%0b ok", pix_addr, pix_data, frame_done);
                    end
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL stray_frame_done actual=1 required=0");
            end
            if (frame_err) err_seen++;
        end
    end

    initial begin
        reset     = 1'b1;
        sck       = 1'b0;
        sdi       = 1'b0;
        cs_n      = 1'b1;
        frame_ack = 1'b0;
        tick(3);
        check("reset_outputs", {pix_valid, pix_data, pix_addr, frame_done, frame_err, overrun, busy}, 0);
        reset = 1'b0;
        tick(3);

        // 1: counting pattern, data = index
        frame_start;
        for (int i = 0; i < NPIX; i++) begin
            send_pixel(PW'(i), 1'b0);
            if (i == 0) check("busy_recv", busy, 1);
        end
        tick(6);
        check("busy_hold", busy, 1);
        check("no_overrun_t1", overrun, 0);
        frame_end;
        ack;
        check("busy_after_ack", busy, 0);
        drain("drain_t1");

        // 2: LSB-first ordering
        frame_start;
        send_pixel(12'h001, 1'b0);
        send_pixel(12'h000, 1'b0);
        send_frame_pixels(NPIX - 2);
        tick(6);
        frame_end;
        ack;
        drain("drain_t2");

        // 3: short frame abort, then a clean frame from addr 0
        frame_start;
        send_frame_pixels(20);
        send_partial(5);
        tick(6);
        frame_end;
        check("frame_err_t3", err_seen, exp_err);
        check("busy_after_abort", busy, 0);
        frame_start;
        send_frame_pixels(NPIX);
        tick(6);
        frame_end;
        ack;
        drain("drain_t3");
        check("frame_err_once_t3", err_seen, exp_err);

        // 4: overrun while held, ack with cs_n low waits for cs_n high
        frame_start;
        send_frame_pixels(NPIX);
        tick(6);
        check("overrun_before", overrun, 0);
        send_partial(20);
        tick(4);
        check("overrun_set", overrun, exp_ovr);
        check("busy_held", busy, 1);
        ack;
        check("overrun_cleared", overrun, exp_ovr);
        check("busy_wait_cs", busy, 0);
        send_partial(5);
        tick(4);
        check("no_overrun_wait", overrun, 0);
        frame_end;
        drain("drain_t4");
        check("frame_err_t4", err_seen, exp_err);

        // 5: reset mid-pixel
        frame_start;
        send_frame_pixels(20);
        send_partial(5);
        tick(6);
        check("queue_empty_pre_reset", exp_q.size(), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_frame", {pix_valid, pix_data, pix_addr, frame_done, frame_err, overrun, busy}, 0);
        cs_n     = 1'b1;
        m_accept = 0;
        m_held   = 0;
        exp_ovr  = 0;
        tick(3);
        reset = 1'b0;
        tick(3);
        frame_start;
        send_frame_pixels(NPIX);
        tick(6);
        frame_end;
        ack;
        drain("drain_t5");

        // 6: last rise coincides with cs_n rising
        frame_start;
        send_frame_pixels(NPIX - 1);
        send_pixel(PW'($urandom), 1'b1);
        if (m_accept) begin
            exp_err++;
            m_accept = 0;
        end
        tick(6);
        check("frame_err_coincident", err_seen, exp_err);
        check("busy_hold_t6", busy, 1);
        ack;
        check("busy_idle_t6", busy, 0);
        ack;
        tick(4);
        check("ack_in_idle_busy", busy, 0);
        check("ack_in_idle_err", err_seen, exp_err);
        frame_start;
        send_frame_pixels(2);
        tick(6);
        frame_end;
        drain("drain_t6");
        check("frame_err_final", err_seen, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
